// File: rtl/clkpll_rstgen_ce.sv
// ---------------------------------------------------------------------------
// clkpll_rstgen_ce
//
// Reset sequencer and clock-enable generator placed right after the system
// PLL. The system is held in reset until the PLL lock flag has stayed high
// for HOLD_CYCLES clocks. After that, single-cycle enables are produced for
// the CPU, PSG and VDP domains, with the same phase after every release.
// Losing lock puts the system back into reset.
//
// Optional feature macro: CLKPLL_TURBO_EN
//   When defined, this adds the turbo_i port. Turbo halves the CPU enable
//   period. The PSG enable stays at half the normal CPU rate.
//
// Ports
//   clk_i     : PLL output clock (outclk_0)
//   rst_i     : synchronous active-high reset
//   locked_i  : PLL lock flag, asynchronous to clk_i
//   turbo_i   : (CLKPLL_TURBO_EN only) CPU turbo request, synchronous
//   sys_rst_o : registered system reset, active-high
//   ready_o   : high while running, always ~sys_rst_o
//   ce_cpu_o  : one-cycle CPU clock enable
//   ce_psg_o  : one-cycle PSG enable at half the normal CPU rate
//   ce_vdp_o  : one-cycle VDP clock enable
// ---------------------------------------------------------------------------
module clkpll_rstgen_ce #(
   parameter int HOLD_CYCLES = 1024,
   parameter int CPU_DIV     = 6,
   parameter int VDP_DIV     = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic locked_i,
`ifdef CLKPLL_TURBO_EN
   input  logic turbo_i,
`endif
   output logic sys_rst_o,
   output logic ready_o,
   output logic ce_cpu_o,
   output logic ce_psg_o,
   output logic ce_vdp_o
);

   localparam int HoldW = $clog2(HOLD_CYCLES);
   localparam int CpuW  = $clog2(CPU_DIV);
   localparam int VdpW  = $clog2(VDP_DIV);

   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
   localparam logic [CpuW-1:0]  CpuLast  = CpuW'(CPU_DIV - 1);
   localparam logic [VdpW-1:0]  VdpLast  = VdpW'(VDP_DIV - 1);

   typedef enum logic [1:0] {
      StWaitLock,
      StHold,
      StRun
   } state_t;

   state_t           state_q, state_d;
   logic [HoldW-1:0] holdCnt_q, holdCnt_d;
   logic             lockMeta_q, lockSync_q;
   logic             sysRst_q, sysRst_d;
   logic             clearDiv;
   logic [CpuW-1:0]  cpuCnt_q, cpuCnt_d;
   logic [VdpW-1:0]  vdpCnt_q, vdpCnt_d;
   logic             ceCpu_q, ceCpu_d;
   logic             ceVdp_q, ceVdp_d;
   logic             cePsg_q, cePsg_d;

`ifdef CLKPLL_TURBO_EN
   localparam int               PsgW     = $clog2(CPU_DIV * 2);
   localparam logic [PsgW-1:0]  PsgLast  = PsgW'(CPU_DIV * 2 - 1);
   localparam logic [CpuW-1:0]  CpuTLast = CpuW'(CPU_DIV / 2 - 1);

   logic             turboLat_q, turboLat_d;
   logic [PsgW-1:0]  psgCnt_q, psgCnt_d;
   logic [CpuW-1:0]  cpuTermCur, cpuTermNext;
`else
   logic             psgTgl_q, psgTgl_d;
`endif

   // Two-flop synchronizer for the asynchronous lock flag. Both flops clear
   // on reset, so a reset always restarts the full lock qualification.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lockMeta_q <= 1'b0;
         lockSync_q <= 1'b0;
      end else begin
         lockMeta_q <= locked_i;
         lockSync_q <= lockMeta_q;
      end
   end

   // Lock sequencing FSM. The hold counter only runs in StHold. Any drop of
   // the synchronized lock sends the FSM back to StWaitLock with the counter
   // cleared, so the whole hold interval has to pass again. The system reset
   // comes from the next state, which makes it fall in the first run cycle.
   always_comb begin
      state_d   = state_q;
      holdCnt_d = '0;
      case (state_q)
         StWaitLock: begin
            if (lockSync_q) state_d = StHold;
         end
         StHold: begin
            if (!lockSync_q)                state_d = StWaitLock;
            else if (holdCnt_q == HoldLast) state_d = StRun;
            else                            holdCnt_d = holdCnt_q + 1'b1;
         end
         StRun: begin
            if (!lockSync_q) state_d = StWaitLock;
         end
         default: state_d = StWaitLock;
      endcase
      sysRst_d = (state_d != StRun);
   end

   // Divider counters stay at zero in every reset cycle. They also stay at
   // zero on the edge that ends reset, so the first run cycle starts at
   // count 0. Each enable is registered from the next count value. An
   // enable is therefore high in the same cycle that its counter shows the
   // terminal value.
   always_comb begin
      clearDiv = sysRst_d | sysRst_q;

`ifdef CLKPLL_TURBO_EN
      cpuTermCur  = turboLat_q ? CpuTLast : CpuLast;
`endif

      cpuCnt_d = '0;
      if (!clearDiv) begin
`ifdef CLKPLL_TURBO_EN
         if (cpuCnt_q != cpuTermCur) cpuCnt_d = cpuCnt_q + 1'b1;
`else
         if (cpuCnt_q != CpuLast) cpuCnt_d = cpuCnt_q + 1'b1;
`endif
      end

      vdpCnt_d = '0;
      if (!clearDiv && (vdpCnt_q != VdpLast)) vdpCnt_d = vdpCnt_q + 1'b1;

      ceVdp_d = !sysRst_d && (vdpCnt_d == VdpLast);

`ifdef CLKPLL_TURBO_EN
      // Turbo is only sampled when a CPU period starts, so a period that
      // is already running always finishes at its original length.
      turboLat_d  = (cpuCnt_d == '0) ? turbo_i : turboLat_q;
      cpuTermNext = turboLat_d ? CpuTLast : CpuLast;
      ceCpu_d     = !sysRst_d && (cpuCnt_d == cpuTermNext);

      psgCnt_d = '0;
      if (!clearDiv && (psgCnt_q != PsgLast)) psgCnt_d = psgCnt_q + 1'b1;
      cePsg_d  = !sysRst_d && (psgCnt_d == PsgLast);
`else
      ceCpu_d  = !sysRst_d && (cpuCnt_d == CpuLast);
      psgTgl_d = clearDiv ? 1'b0 : (psgTgl_q ^ ceCpu_q);
      cePsg_d  = ceCpu_d && psgTgl_q;
`endif
   end

   // State, hold counter, dividers and registered outputs. Reset takes
   // priority and forces the system into reset with all enables off.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StWaitLock;
         holdCnt_q <= '0;
         sysRst_q  <= 1'b1;
         cpuCnt_q  <= '0;
         vdpCnt_q  <= '0;
         ceCpu_q   <= 1'b0;
         ceVdp_q   <= 1'b0;
         cePsg_q   <= 1'b0;
`ifdef CLKPLL_TURBO_EN
         turboLat_q <= 1'b0;
         psgCnt_q   <= '0;
`else
         psgTgl_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         holdCnt_q <= holdCnt_d;
         sysRst_q  <= sysRst_d;
         cpuCnt_q  <= cpuCnt_d;
         vdpCnt_q  <= vdpCnt_d;
         ceCpu_q   <= ceCpu_d;
         ceVdp_q   <= ceVdp_d;
         cePsg_q   <= cePsg_d;
`ifdef CLKPLL_TURBO_EN
         turboLat_q <= turboLat_d;
         psgCnt_q   <= psgCnt_d;
`else
         psgTgl_q  <= psgTgl_d;
`endif
      end
   end

   assign sys_rst_o = sysRst_q;
   assign ready_o   = ~sysRst_q;
   assign ce_cpu_o  = ceCpu_q;
   assign ce_psg_o  = cePsg_q;
   assign ce_vdp_o  = ceVdp_q;

endmodule

// File: tb/tb_clkpll_rstgen_ce.sv
// ---------------------------------------------------------------------------
// tb_clkpll_rstgen_ce
//
// Self-checking bench for clkpll_rstgen_ce with default parameters.
// Expected enable patterns come from the cycle formulas of the block, with
// cycle 0 as the first cycle out of reset. They are pushed to a scoreboard
// queue and checked at the falling clock edge. Fixed enable phase points
// are listed in a vector table. Reset and lock sequences are checked by
// hand-written steps.
// ---------------------------------------------------------------------------
module tb_clkpll_rstgen_ce;

   localparam int HoldCycles = 1024;
   localparam int CpuDiv     = 6;
   localparam int VdpDiv     = 4;
   localparam int ReleaseLat = 2 + HoldCycles + 1;

   logic clk_i = 1'b0;
   logic rst_i;
   logic locked_i;
   logic turbo_i;
   logic sys_rst_o;
   logic ready_o;
   logic ce_cpu_o;
   logic ce_psg_o;
   logic ce_vdp_o;

   int nCompared   = 0;
   int nMismatched = 0;

   typedef struct {
      string name;
      int    runCycle;
      logic  expCpu;
      logic  expVdp;
      logic  expPsg;
   } phaseVec_t;

   typedef struct {
      string name;
      logic  sysRst;
      logic  ready;
      logic  cpu;
      logic  vdp;
      logic  psg;
   } expect_t;

   expect_t sbQ[$];

   clkpll_rstgen_ce #(
      .HOLD_CYCLES(HoldCycles),
      .CPU_DIV    (CpuDiv),
      .VDP_DIV    (VdpDiv)
   ) dut (
`ifdef CLKPLL_TURBO_EN
      .turbo_i  (turbo_i),
`endif
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .locked_i (locked_i),
      .sys_rst_o(sys_rst_o),
      .ready_o  (ready_o),
      .ce_cpu_o (ce_cpu_o),
      .ce_psg_o (ce_psg_o),
      .ce_vdp_o (ce_vdp_o)
   );

   // Free-running 100 MHz-style bench clock.
   always #5 clk_i = ~clk_i;

   // Hard stop if the sequence ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time expired, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rstVal, input logic lockVal);
      rst_i    = rstVal;
      locked_i = lockVal;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Waits for sys_rst_o to fall, counting clocks. Checks the latency and
   // checks that no enable or ready is seen while reset is still high.
   task automatic waitRelease(input string name);
      int   n = 0;
      logic sawEnable = 1'b0;
      while (sys_rst_o === 1'b1 && n < ReleaseLat + 64) begin
         if (ce_cpu_o || ce_vdp_o || ce_psg_o || ready_o) sawEnable = 1'b1;
         step();
         n++;
      end
      checkOutput({name, "_latency"}, n, ReleaseLat);
      checkOutput({name, "_quietInReset"}, sawEnable, 1'b0);
   endtask

   // Scoreboard monitor: one expected record per cycle, compared mid-cycle.
   always @(negedge clk_i) begin : scoreboardMon
      expect_t e;
      if (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         checkOutput(e.name,
                     {27'd0, sys_rst_o, ready_o, ce_cpu_o, ce_vdp_o, ce_psg_o},
                     {27'd0, e.sysRst, e.ready, e.cpu, e.vdp, e.psg});
      end
   end

   initial begin
      phaseVec_t vecs[9];
      int        cyc;
      int        cntCpu, cntVdp, cntPsg;
      int        firstCpu, firstVdp, firstPsg;
      logic      stayed;

      vecs[0] = '{name:"phase_c0",  runCycle:0,  expCpu:0, expVdp:0, expPsg:0};
      vecs[1] = '{name:"phase_c2",  runCycle:2,  expCpu:0, expVdp:0, expPsg:0};
      vecs[2] = '{name:"phase_c3",  runCycle:3,  expCpu:0, expVdp:1, expPsg:0};
      vecs[3] = '{name:"phase_c5",  runCycle:5,  expCpu:1, expVdp:0, expPsg:0};
      vecs[4] = '{name:"phase_c7",  runCycle:7,  expCpu:0, expVdp:1, expPsg:0};
      vecs[5] = '{name:"phase_c11", runCycle:11, expCpu:1, expVdp:1, expPsg:1};
      vecs[6] = '{name:"phase_c12", runCycle:12, expCpu:0, expVdp:0, expPsg:0};
      vecs[7] = '{name:"phase_c17", runCycle:17, expCpu:1, expVdp:0, expPsg:0};
      vecs[8] = '{name:"phase_c23", runCycle:23, expCpu:1, expVdp:1, expPsg:1};

      turbo_i = 1'b0;
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput($sformatf("reset%0d", i),
                     {sys_rst_o, ready_o, ce_cpu_o, ce_vdp_o, ce_psg_o}, 5'b10000);
      end
      applyStimulus(1'b0, 1'b1);
      waitRelease("rstRelease");

      $display("[TB] steady run, 120 cycles");
      cntCpu = 0; cntVdp = 0; cntPsg = 0;
      firstCpu = -1; firstVdp = -1; firstPsg = -1;
      for (int k = 0; k < 120; k++) begin
         sbQ.push_back('{name:$sformatf("run%0d", k), sysRst:1'b0, ready:1'b1,
                         cpu:((k + 1) % CpuDiv == 0),
                         vdp:((k + 1) % VdpDiv == 0),
                         psg:((k + 1) % (2 * CpuDiv) == 0)});
         if (ce_cpu_o === 1'b1) begin cntCpu++; if (firstCpu < 0) firstCpu = k; end
         if (ce_vdp_o === 1'b1) begin cntVdp++; if (firstVdp < 0) firstVdp = k; end
         if (ce_psg_o === 1'b1) begin cntPsg++; if (firstPsg < 0) firstPsg = k; end
         step();
      end
      checkOutput("countCpu", cntCpu, 20);
      checkOutput("countVdp", cntVdp, 30);
      checkOutput("countPsg", cntPsg, 10);
      checkOutput("firstCpu", firstCpu, 5);
      checkOutput("firstVdp", firstVdp, 3);
      checkOutput("firstPsg", firstPsg, 11);

      $display("[TB] lock loss after steady run");
      applyStimulus(1'b0, 1'b0);
      repeat (2) step();
      checkOutput("dropA_stillRunning", sys_rst_o, 1'b0);
      step();
      checkOutput("dropA_inReset", {sys_rst_o, ce_cpu_o, ce_vdp_o, ce_psg_o}, 4'b1000);
      repeat (3) step();

      $display("[TB] lock glitch at hold count 500");
      applyStimulus(1'b0, 1'b1);
      stayed = 1'b1;
      repeat (503) begin
         step();
         if (sys_rst_o !== 1'b1) stayed = 1'b0;
      end
      applyStimulus(1'b0, 1'b0);
      repeat (4) begin
         step();
         if (sys_rst_o !== 1'b1) stayed = 1'b0;
      end
      applyStimulus(1'b0, 1'b1);
      checkOutput("glitch_heldInReset", stayed, 1'b1);
      waitRelease("glitchRelock");

      $display("[TB] enable phase table after relock");
      cyc = 0;
      foreach (vecs[i]) begin
         while (cyc < vecs[i].runCycle) begin
            step();
            cyc++;
         end
         checkOutput(vecs[i].name, {sys_rst_o, ce_cpu_o, ce_vdp_o, ce_psg_o},
                     {1'b0, vecs[i].expCpu, vecs[i].expVdp, vecs[i].expPsg});
      end
      while (cyc < 40) begin
         step();
         cyc++;
      end
      applyStimulus(1'b0, 1'b0);
      step();
      checkOutput("drop_c41", sys_rst_o, 1'b0);
      step();
      checkOutput("drop_c42", sys_rst_o, 1'b0);
      step();
      checkOutput("drop_c43", {sys_rst_o, ready_o, ce_cpu_o, ce_vdp_o, ce_psg_o}, 5'b10000);

      applyStimulus(1'b0, 1'b1);
      waitRelease("relockAfterDrop");

      $display("[TB] one-cycle rst pulse mid-run");
      repeat (20) step();
      applyStimulus(1'b1, 1'b1);
      step();
      checkOutput("rstPulse", {sys_rst_o, ready_o, ce_cpu_o, ce_vdp_o, ce_psg_o}, 5'b10000);
      applyStimulus(1'b0, 1'b1);
      waitRelease("rstPulseResequence");

`ifdef CLKPLL_TURBO_EN
      $display("[TB] turbo raised at cycle 2");
      for (int k = 0; k < 36; k++) begin
         if (k == 2) turbo_i = 1'b1;
         sbQ.push_back('{name:$sformatf("turbo%0d", k), sysRst:1'b0, ready:1'b1,
                         cpu:((k == 5) || (k >= 8 && (k - 8) % 3 == 0)),
                         vdp:((k + 1) % VdpDiv == 0),
                         psg:((k + 1) % (2 * CpuDiv) == 0)});
         step();
      end
      turbo_i = 1'b0;
`endif

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
